// File: rtl/delay_mc_prog.sv
// delay_mc_prog: multi-channel, run-time programmable, counter-timed matched-delay element
// Optional completion-hold timeout with sticky err is enabled by defining DELAY_TIMEOUT_EN.
module delay_mc_prog #(
    parameter int CH       = 4,
    parameter int DW       = 8,
    parameter int SYNC_STG = 2,
    parameter int PULSE    = 0,
    parameter int TO_CYC   = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CH-1:0]    req,
    input  logic [CH*DW-1:0] dly_cfg,
    output logic [CH-1:0]    fin,
    output logic [CH-1:0]    busy,
    output logic [CH-1:0]    err,
    input  logic [CH-1:0]    err_clr
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE, WAIT_LOW} state_t;
    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [SYNC_STG-1:0] sync;
        logic [DW-1:0]       cnt;
        logic [DW-1:0]       d;
        logic                req_s;
        logic                fin_q;
        logic                busy_q;
        state_t              st;
        state_t              nxt;
        assign req_s = sync[SYNC_STG-1];
        assign d     = dly_cfg[g*DW +: DW];
        // Any drop of req_s returns the channel to IDLE, aborting a count in flight.
        assign nxt = !req_s        ? IDLE :
                     (st == IDLE)  ? ((d <= DW'(1)) ? DONE : COUNT) :
                     (st == COUNT) ? ((cnt == DW'(1)) ? DONE : COUNT) :
                     (st == DONE)  ? ((PULSE != 0) ? WAIT_LOW : DONE) : WAIT_LOW;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                sync   <= '0;
                st     <= IDLE;
                cnt    <= '0;
                fin_q  <= 1'b0;
                busy_q <= 1'b0;
            end else begin
                sync   <= {sync[SYNC_STG-2:0], req[g]};
                st     <= nxt;
                fin_q  <= nxt == DONE;
                busy_q <= nxt != IDLE;
                // Loading every IDLE cycle is harmless: cnt is only consulted in COUNT.
                if (st == IDLE)
                    cnt <= d - DW'(1);
                else if (st == COUNT)
                    cnt <= cnt - DW'(1);
            end
        end
        assign fin[g]  = fin_q;
        assign busy[g] = busy_q;
`ifdef DELAY_TIMEOUT_EN
        localparam int TW = $clog2(TO_CYC + 1);
        logic [TW-1:0] to_cnt;
        logic          err_q;
        logic          hold;
        assign hold = (st == DONE) || (st == WAIT_LOW);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                to_cnt <= '0;
                err_q  <= 1'b0;
            end else begin
                to_cnt <= !hold ? '0 : (to_cnt == TW'(TO_CYC)) ? to_cnt : to_cnt + 1'b1;
                err_q  <= (hold && req_s && to_cnt == TW'(TO_CYC - 1)) || (err_q && !err_clr[g]);
            end
        end
        assign err[g] = err_q;
`else
        logic unused_clr;
        assign unused_clr = err_clr[g] ^ (TO_CYC == 0);
        assign err[g]     = 1'b0;
`endif
    end
endmodule

// File: tb/tb_delay_mc_prog.sv
// tb_delay_mc_prog: randomized and directed checks of delay_mc_prog (level and pulse variants)
// against an elapsed-time reference model.
module tb_delay_mc_prog;
    localparam int CH = 4;
    localparam int DW = 8;
    localparam int SS = 2;
    localparam int TO = 8;
`ifdef DELAY_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif
    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CH-1:0]    req = '0;
    logic [CH-1:0]    err_clr = '0;
    logic [CH*DW-1:0] dly_cfg = '0;
    logic [CH-1:0]    fin [2];
    logic [CH-1:0]    busy [2];
    logic [CH-1:0]    err [2];
    logic [CH-1:0]    rq [SS];
    bit               act [2][CH];
    int               t0 [2][CH];
    int               dv [2][CH];
    logic [CH-1:0]    m_fin [2];
    logic [CH-1:0]    m_busy [2];
    logic [CH-1:0]    m_err [2];
    int               n = 0;
    int               checks = 0;
    int               errors = 0;

    always #5 clk = ~clk;

    delay_mc_prog #(.CH(CH), .DW(DW), .SYNC_STG(SS), .PULSE(0), .TO_CYC(TO)) u_lvl (
        .clk(clk), .rst_n(rst_n), .req(req), .dly_cfg(dly_cfg),
        .fin(fin[0]), .busy(busy[0]), .err(err[0]), .err_clr(err_clr)
    );
    delay_mc_prog #(.CH(CH), .DW(DW), .SYNC_STG(SS), .PULSE(1), .TO_CYC(TO)) u_pls (
        .clk(clk), .rst_n(rst_n), .req(req), .dly_cfg(dly_cfg),
        .fin(fin[1]), .busy(busy[1]), .err(err[1]), .err_clr(err_clr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Model: a channel is active from the cycle req_s is first seen high until
    // req_s drops; fin depends only on cycles elapsed since that start.
    task automatic step();
        logic [CH-1:0] rs;
        int d;
        int el;
        n++;
        if (!rst_n) begin
            for (int s = 0; s < SS; s++) rq[s] = '0;
            for (int m = 0; m < 2; m++) begin
                for (int c = 0; c < CH; c++) act[m][c] = 1'b0;
                m_fin[m] = '0; m_busy[m] = '0; m_err[m] = '0;
            end
            return;
        end
        rs = rq[SS-1];
        for (int m = 0; m < 2; m++) begin
            for (int c = 0; c < CH; c++) begin
                d = int'(dly_cfg[c*DW +: DW]);
                if (!rs[c]) act[m][c] = 1'b0;
                else if (!act[m][c]) begin
                    act[m][c] = 1'b1;
                    t0[m][c]  = n - 1;
                    dv[m][c]  = (d == 0) ? 1 : d;
                end
                el = n - t0[m][c];
                m_busy[m][c] = act[m][c];
                m_fin[m][c]  = act[m][c] && ((m == 1) ? (el == dv[m][c]) : (el >= dv[m][c]));
                m_err[m][c]  = TO_EN && ((act[m][c] && el == dv[m][c] + TO) || (m_err[m][c] && !err_clr[c]));
            end
        end
        for (int s = SS - 1; s > 0; s--) rq[s] = rq[s-1];
        rq[0] = req;
    endtask

    task automatic tick();
        @(posedge clk);
        step();
        @(negedge clk);
        for (int m = 0; m < 2; m++) begin
            check($sformatf("fin%0d@%0d", m, n), 32'(fin[m]), 32'(m_fin[m]));
            check($sformatf("busy%0d@%0d", m, n), 32'(busy[m]), 32'(m_busy[m]));
            check($sformatf("err%0d@%0d", m, n), 32'(err[m]), 32'(m_err[m]));
        end
    endtask

    task automatic ticks(input int k);
        repeat (k) tick();
    endtask

    task automatic set_d(input int c, input int v);
        dly_cfg[c*DW +: DW] = DW'(v);
    endtask

    task automatic do_reset(input int k);
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            check($sformatf("rst_fin%0d", m), 32'(fin[m]), 32'd0);
            check($sformatf("rst_busy%0d", m), 32'(busy[m]), 32'd0);
            check($sformatf("rst_err%0d", m), 32'(err[m]), 32'd0);
        end
        ticks(k);
        rst_n = 1'b1;
    endtask

    initial begin
        for (int s = 0; s < SS; s++) rq[s] = '0;
        ticks(2);
        rst_n = 1'b1;
        ticks(2);
        // single channel, D=5
        set_d(0, 5); req[0] = 1'b1; ticks(12);
        req[0] = 1'b0; ticks(4);
        // D=0, D=1, D=255 side by side, then clear any timeout flags
        set_d(1, 0); set_d(2, 1); set_d(3, 255);
        req[3:1] = 3'b111; ticks(262);
        err_clr = '1; tick(); err_clr = '0;
        req = '0; ticks(4);
        // abort mid-count, then a full count
        set_d(0, 10); req[0] = 1'b1; ticks(6);
        req[0] = 1'b0; ticks(4);
        req[0] = 1'b1; ticks(14);
        req[0] = 1'b0; ticks(4);
        // long hold with D=3, then re-trigger
        set_d(0, 3); req[0] = 1'b1; ticks(20);
        req[0] = 1'b0; ticks(4);
        req[0] = 1'b1; ticks(8);
        req[0] = 1'b0; ticks(4);
        // staggered channels, configuration changed mid-count
        set_d(0, 3); set_d(1, 7); set_d(2, 1); set_d(3, 12);
        for (int c = 0; c < CH; c++) begin
            req[c] = 1'b1;
            ticks(2);
        end
        tick();
        dly_cfg = CH*DW'($urandom);
        ticks(16);
        req = '0; ticks(4);
        // reset during COUNT (ch0) and DONE (ch1)
        set_d(0, 20); set_d(1, 1);
        req = 4'b0011; ticks(8);
        do_reset(2);
        ticks(6);
        req = '0; ticks(4);
        // timeout set while holding, clear while still holding
        set_d(0, 2); req[0] = 1'b1; ticks(14);
        err_clr[0] = 1'b1; tick(); err_clr[0] = 1'b0;
        ticks(3);
        req[0] = 1'b0; ticks(4);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(7) == 0) req[c] = ~req[c];
                if ($urandom_range(15) == 0) set_d(c, int'($urandom_range(15)));
                err_clr[c] = ($urandom_range(15) == 0);
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
